// File: rtl/dfi_chan_mux.sv
// dfi_chan_mux: round-robin multiplexer of NUM_CHANNELS MMC command channels onto a single
// PHY command/data port, with an in-order read-tag FIFO that steers PHY read returns back to
// the channel that issued them, and an init_done strobe after a programmable settle count.
//
// Optional feature (macro DFI_RD_TIMEOUT_EN): age counter on the oldest outstanding read that
// raises a sticky dfi__mmc__rd_timeout after RD_TIMEOUT cycles without a return. When the macro
// is not defined the flag is tied low and no counter exists.
//
// Assumes NUM_CHANNELS >= 2 and RD_TAG_DEPTH a power of two >= 2.

module dfi_chan_mux #(
    parameter int NUM_CHANNELS = 2,
    parameter int NUM_WORDS    = 4,
    parameter int WORD_WIDTH   = 32,
    parameter int BANK_WIDTH   = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int RD_TAG_DEPTH = 8,
    parameter int INIT_CYCLES  = 16,
    parameter int RD_TIMEOUT   = 256
) (
    input  logic                                          clk,
    input  logic                                          reset_poweron_n,

    output logic                                          dfi__mmc__init_done,

    input  logic [NUM_CHANNELS-1:0]                       mmc__dfi__valid,
    output logic [NUM_CHANNELS-1:0]                       dfi__mmc__ready,
    input  logic [2*NUM_CHANNELS-1:0]                     mmc__dfi__cmd,
    input  logic [BANK_WIDTH*NUM_CHANNELS-1:0]            mmc__dfi__bank,
    input  logic [ADDR_WIDTH*NUM_CHANNELS-1:0]            mmc__dfi__addr,
    input  logic [NUM_WORDS*WORD_WIDTH*NUM_CHANNELS-1:0]  mmc__dfi__data,

    output logic [NUM_CHANNELS-1:0]                       dfi__mmc__valid,
    output logic [NUM_WORDS*WORD_WIDTH*NUM_CHANNELS-1:0]  dfi__mmc__data,
    output logic                                          dfi__mmc__rd_timeout,

    output logic                                          dfi__phy__cs,
    output logic                                          dfi__phy__cmd1,
    output logic                                          dfi__phy__cmd0,
    output logic [BANK_WIDTH-1:0]                         dfi__phy__bank,
    output logic [ADDR_WIDTH-1:0]                         dfi__phy__addr,
    output logic [NUM_WORDS*WORD_WIDTH-1:0]               dfi__phy__data,

    input  logic                                          phy__dfi__valid,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0]               phy__dfi__data
);

    localparam int BEAT_W = NUM_WORDS * WORD_WIDTH;
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int TAG_W  = (RD_TAG_DEPTH > 1) ? $clog2(RD_TAG_DEPTH) : 1;
    localparam int CNT_W  = TAG_W + 1;
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_WR = 2'b10;

    // ------------------------------------------------------------------
    // Init settle timer
    // ------------------------------------------------------------------
    logic [INIT_W-1:0] init_cnt;

    // Down-count from INIT_CYCLES; init_done is set on the edge the count expires and then holds.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            init_cnt            <= INIT_W'(INIT_CYCLES);
            dfi__mmc__init_done <= 1'b0;
        end else if (!dfi__mmc__init_done) begin
            if (init_cnt <= INIT_W'(1)) begin
                dfi__mmc__init_done <= 1'b1;
            end
            if (init_cnt != '0) begin
                init_cnt <= init_cnt - INIT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-tag FIFO state (declared early: its count gates read eligibility)
    // ------------------------------------------------------------------
    logic [CH_W-1:0]  tag_mem [RD_TAG_DEPTH];
    logic [TAG_W-1:0] tag_wr_ptr;
    logic [TAG_W-1:0] tag_rd_ptr;
    logic [CNT_W-1:0] tag_cnt;
    logic             tag_push;
    logic             tag_pop;
    logic [CH_W-1:0]  pop_tag;
    logic             rd_room;

    assign rd_room = (tag_cnt < CNT_W'(RD_TAG_DEPTH));

    // ------------------------------------------------------------------
    // Eligibility and round-robin arbitration
    // ------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0] elig;
    logic [CH_W-1:0]         rr_ptr;
    logic [CH_W-1:0]         rr_next;
    logic [CH_W:0]           cand;
    logic                    grant_any;
    logic [CH_W-1:0]         grant_idx;

    // A channel may be granted only after init, with a legal command, and for reads only while
    // the tag FIFO (registered count, no same-cycle pop credit) has room.
    always_comb begin
        elig = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (dfi__mmc__init_done && mmc__dfi__valid[c]) begin
                if (mmc__dfi__cmd[2*c +: 2] == CMD_WR) begin
                    elig[c] = 1'b1;
                end else if (mmc__dfi__cmd[2*c +: 2] == CMD_RD && rd_room) begin
                    elig[c] = 1'b1;
                end
            end
        end
    end

    // Scan channels starting at the RR pointer; first eligible one wins the single grant.
    always_comb begin
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            cand = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(NUM_CHANNELS)) begin
                cand = cand - (CH_W+1)'(NUM_CHANNELS);
            end
            if (!grant_any && elig[cand[CH_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[CH_W-1:0];
            end
        end
    end

    // One-hot ready and the pointer value that follows a grant.
    always_comb begin
        dfi__mmc__ready = '0;
        rr_next         = rr_ptr;
        if (grant_any) begin
            dfi__mmc__ready[grant_idx] = 1'b1;
            if (grant_idx == CH_W'(NUM_CHANNELS - 1)) begin
                rr_next = '0;
            end else begin
                rr_next = grant_idx + CH_W'(1);
            end
        end
    end

    // Pointer advances past the granted channel; holds when nothing is granted.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
        end
    end

    // ------------------------------------------------------------------
    // Granted-channel field select
    // ------------------------------------------------------------------
    logic [1:0]            sel_cmd;
    logic [BANK_WIDTH-1:0] sel_bank;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BEAT_W-1:0]     sel_data;

    // Pick the winner's command fields; zero when idle so the PHY port idles at 0.
    always_comb begin
        sel_cmd  = '0;
        sel_bank = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (grant_any && grant_idx == CH_W'(c)) begin
                sel_cmd  = mmc__dfi__cmd[2*c +: 2];
                sel_bank = mmc__dfi__bank[BANK_WIDTH*c +: BANK_WIDTH];
                sel_addr = mmc__dfi__addr[ADDR_WIDTH*c +: ADDR_WIDTH];
                sel_data = mmc__dfi__data[BEAT_W*c +: BEAT_W];
            end
        end
    end

    // Register the granted command onto the PHY port one cycle after the handshake.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            dfi__phy__cs   <= 1'b0;
            dfi__phy__cmd1 <= 1'b0;
            dfi__phy__cmd0 <= 1'b0;
            dfi__phy__bank <= '0;
            dfi__phy__addr <= '0;
            dfi__phy__data <= '0;
        end else begin
            dfi__phy__cs   <= grant_any;
            dfi__phy__cmd1 <= sel_cmd[1];
            dfi__phy__cmd0 <= sel_cmd[0];
            dfi__phy__bank <= sel_bank;
            dfi__phy__addr <= sel_addr;
            dfi__phy__data <= sel_data;
        end
    end

    // ------------------------------------------------------------------
    // Read-tag FIFO
    // ------------------------------------------------------------------
    assign tag_push = grant_any && (sel_cmd == CMD_RD);
    // A return with nothing outstanding is spurious and ignored entirely.
    assign tag_pop  = phy__dfi__valid && (tag_cnt != '0);
    assign pop_tag  = tag_mem[tag_rd_ptr];

    // Tag storage; contents are don't-care until pushed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[tag_wr_ptr] <= grant_idx;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_cnt    <= '0;
        end else begin
            if (tag_push) begin
                tag_wr_ptr <= tag_wr_ptr + TAG_W'(1);
            end
            if (tag_pop) begin
                tag_rd_ptr <= tag_rd_ptr + TAG_W'(1);
            end
            if (tag_push && !tag_pop) begin
                tag_cnt <= tag_cnt + CNT_W'(1);
            end else if (!tag_push && tag_pop) begin
                tag_cnt <= tag_cnt - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return routing
    // ------------------------------------------------------------------
    // Strobe the tagged channel for one cycle and load only its data slice; others hold.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            dfi__mmc__valid <= '0;
            dfi__mmc__data  <= '0;
        end else begin
            dfi__mmc__valid <= '0;
            if (tag_pop) begin
                dfi__mmc__valid[pop_tag] <= 1'b1;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (tag_pop && pop_tag == CH_W'(c)) begin
                    dfi__mmc__data[BEAT_W*c +: BEAT_W] <= phy__dfi__data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Oldest-read timeout
    // ------------------------------------------------------------------
`ifdef DFI_RD_TIMEOUT_EN
    localparam int AGE_W = $clog2(RD_TIMEOUT + 1);

    logic [AGE_W-1:0] age_cnt;

    // Down-counter reloaded whenever the oldest read retires or nothing is outstanding;
    // hitting terminal count while a read is still waiting sets the sticky flag.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            age_cnt              <= AGE_W'(RD_TIMEOUT);
            dfi__mmc__rd_timeout <= 1'b0;
        end else if (tag_pop || tag_cnt == '0) begin
            age_cnt <= AGE_W'(RD_TIMEOUT);
        end else begin
            if (age_cnt != '0) begin
                age_cnt <= age_cnt - AGE_W'(1);
            end
            if (age_cnt == AGE_W'(1)) begin
                dfi__mmc__rd_timeout <= 1'b1;
            end
        end
    end
`else
    assign dfi__mmc__rd_timeout = 1'b0;
`endif

endmodule
